// File: rtl/crc_stream_if.sv
// Handshake bundle for the streaming CRC engine: an input beat channel
// (s_*), a synchronous abort (clear) and a result channel (m_*).
// The producer/consumer side uses master; the engine itself uses slave.
interface crc_stream_if #(
   parameter int DATA_W = 32,
   parameter int CRC_W  = 10,
   parameter int CNT_W  = 16
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              clear;
   logic              m_valid;
   logic              m_ready;
   logic [CRC_W-1:0]  m_crc;
   logic [CNT_W-1:0]  m_beats;

   modport master (
      output s_valid, s_data, s_last, clear, m_ready,
      input  s_ready, m_valid, m_crc, m_beats
   );

   modport slave (
      input  s_valid, s_data, s_last, clear, m_ready,
      output s_ready, m_valid, m_crc, m_beats
   );
endinterface

// File: rtl/crc_stream.sv
// Parametrised streaming CRC engine. Folds a whole DATA_W-bit beat per
// cycle, counts beats (saturating) and hands back the finished CRC and
// beat count over a valid/ready result channel.
module crc_stream #(
   parameter int               CRC_W       = 10,
   parameter logic [CRC_W-1:0] POLY        = 10'h233,
   parameter int               DATA_W      = 32,
   parameter logic [CRC_W-1:0] INIT        = '0,
   parameter logic [CRC_W-1:0] XOR_OUT     = '0,
   parameter bit               LSB_FIRST   = 1'b0,
   parameter bit               REFLECT_OUT = 1'b0,
   parameter int               CNT_W       = 16
) (
   input logic         clk,
   input logic         rst_n,
   crc_stream_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [CRC_W-1:0]   r_crc;
   logic [CRC_W-1:0]   w_crcNext;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cntNext;
   logic               r_mValid;
   logic               w_mValidNext;
   logic [CRC_W-1:0]   r_mCrc;
   logic [CNT_W-1:0]   r_mBeats;
   logic               w_loadResult;
   logic               w_sReady;
   logic               w_accept;
   logic [CRC_W-1:0]   w_stepBase;
   logic [CRC_W-1:0]   w_stepped;
   logic [CRC_W-1:0]   w_result;
   logic [CNT_W-1:0]   w_cntInc;

   // Galois (non-augmented) CRC update over every bit of one beat,
   // unrolled so the whole beat folds in a single cycle.
   function automatic logic [CRC_W-1:0] crcStep(input logic [CRC_W-1:0] base,
                                                input logic [DATA_W-1:0] data);
      logic [CRC_W-1:0] c;
      logic             b;
      logic             fb;
      c = base;
      for (int i = 0; i < DATA_W; i++) begin
         b  = LSB_FIRST ? data[i] : data[DATA_W-1-i];
         fb = c[CRC_W-1] ^ b;
         c  = (c << 1) ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   // Bit reversal used for reflected-output CRC variants.
   function automatic logic [CRC_W-1:0] reverseBits(input logic [CRC_W-1:0] c);
      logic [CRC_W-1:0] r;
      r = '0;
      for (int i = 0; i < CRC_W; i++) begin
         r[i] = c[CRC_W-1-i];
      end
      return r;
   endfunction

   // Datapath: a frame's first beat starts from INIT, later beats from the
   // running register; the count saturates so long frames never wrap.
   always_comb begin
      w_sReady   = (r_state != DONE);
      w_accept   = bus.s_valid && w_sReady;
      w_stepBase = (r_state == IDLE) ? INIT : r_crc;
      w_stepped  = crcStep(w_stepBase, bus.s_data);
      w_result   = (REFLECT_OUT ? reverseBits(w_stepped) : w_stepped) ^ XOR_OUT;
      if (r_state == IDLE) begin
         w_cntInc = CNT_W'(1);
      end else if (r_cnt == '1) begin
         w_cntInc = r_cnt;
      end else begin
         w_cntInc = r_cnt + CNT_W'(1);
      end
   end

   // Next-state logic: clear beats accept while collecting, but a finished
   // result in DONE is always delivered before going back to IDLE.
   always_comb begin
      w_stateNext  = r_state;
      w_crcNext    = r_crc;
      w_cntNext    = r_cnt;
      w_mValidNext = r_mValid;
      w_loadResult = 1'b0;
      case (r_state)
         IDLE, RUN: begin
            if (bus.clear) begin
               w_stateNext = IDLE;
               w_crcNext   = INIT;
               w_cntNext   = '0;
            end else if (w_accept) begin
               w_crcNext = w_stepped;
               w_cntNext = w_cntInc;
               if (bus.s_last) begin
                  w_loadResult = 1'b1;
                  w_mValidNext = 1'b1;
                  w_stateNext  = DONE;
               end else begin
                  w_stateNext = RUN;
               end
            end
         end
         DONE: begin
            if (r_mValid && bus.m_ready) begin
               w_mValidNext = 1'b0;
               w_crcNext    = INIT;
               w_cntNext    = '0;
               w_stateNext  = IDLE;
            end
         end
         default: begin
            w_stateNext  = IDLE;
            w_crcNext    = INIT;
            w_cntNext    = '0;
            w_mValidNext = 1'b0;
         end
      endcase
   end

   // State, running CRC and count registers; reset drops any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_crc    <= INIT;
         r_cnt    <= '0;
         r_mValid <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_crc    <= w_crcNext;
         r_cnt    <= w_cntNext;
         r_mValid <= w_mValidNext;
      end
   end

   // Result registers load only when the last beat is taken, so they stay
   // stable for the whole time the result is waiting in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mCrc   <= '0;
         r_mBeats <= '0;
      end else if (w_loadResult) begin
         r_mCrc   <= w_result;
         r_mBeats <= w_cntInc;
      end
   end

   assign bus.s_ready = w_sReady;
   assign bus.m_valid = r_mValid;
   assign bus.m_crc   = r_mCrc;
   assign bus.m_beats = r_mBeats;

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: four instances (default CRC-10,
// CRC-16/CCITT-FALSE, CRC-32, and CCITT with a 2-bit beat counter).
module tb_crc_stream;

   logic clk;
   logic rst_n;
   int   checkCount = 0;
   int   errorCount = 0;

   logic [7:0]  digits [9];
   logic [63:0] aExpCrc[$], aExpBeats[$];
   logic [63:0] bExpCrc[$], bExpBeats[$];
   logic [63:0] cExpCrc[$], cExpBeats[$];
   logic [63:0] dExpCrc[$], dExpBeats[$];

   crc_stream_if #(.DATA_W(32), .CRC_W(10), .CNT_W(16)) aIf();
   crc_stream_if #(.DATA_W(8),  .CRC_W(16), .CNT_W(16)) bIf();
   crc_stream_if #(.DATA_W(8),  .CRC_W(32), .CNT_W(16)) cIf();
   crc_stream_if #(.DATA_W(8),  .CRC_W(16), .CNT_W(2))  dIf();

   crc_stream dutA (.clk(clk), .rst_n(rst_n), .bus(aIf));

   crc_stream #(.CRC_W(16), .POLY(16'h1021), .DATA_W(8), .INIT(16'hFFFF),
                .XOR_OUT(16'h0000), .LSB_FIRST(1'b0), .REFLECT_OUT(1'b0), .CNT_W(16))
      dutB (.clk(clk), .rst_n(rst_n), .bus(bIf));

   crc_stream #(.CRC_W(32), .POLY(32'h04C11DB7), .DATA_W(8), .INIT(32'hFFFFFFFF),
                .XOR_OUT(32'hFFFFFFFF), .LSB_FIRST(1'b1), .REFLECT_OUT(1'b1), .CNT_W(16))
      dutC (.clk(clk), .rst_n(rst_n), .bus(cIf));

   crc_stream #(.CRC_W(16), .POLY(16'h1021), .DATA_W(8), .INIT(16'hFFFF),
                .XOR_OUT(16'h0000), .LSB_FIRST(1'b0), .REFLECT_OUT(1'b0), .CNT_W(2))
      dutD (.clk(clk), .rst_n(rst_n), .bus(dIf));

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case some handshake never completes.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Bit-serial reference of one beat, written straight from the CRC definition.
   function automatic logic [63:0] refStep(input logic [63:0] crc, input logic [127:0] data,
                                           input int crcW, input int dataW,
                                           input logic [63:0] poly, input bit lsbFirst);
      logic [63:0] mask;
      logic        b;
      logic        fb;
      mask = (crcW == 64) ? '1 : ((64'd1 << crcW) - 64'd1);
      for (int i = 0; i < dataW; i++) begin
         b   = lsbFirst ? data[i] : data[dataW-1-i];
         fb  = crc[crcW-1] ^ b;
         crc = ((crc << 1) & mask) ^ (fb ? poly : 64'd0);
      end
      return crc;
   endfunction

   // Output reflection and final XOR of the reference.
   function automatic logic [63:0] refFinal(input logic [63:0] crc, input int crcW,
                                            input bit reflect, input logic [63:0] xorOut);
      logic [63:0] r;
      r = crc;
      if (reflect) begin
         r = '0;
         for (int i = 0; i < crcW; i++) r[i] = crc[crcW-1-i];
      end
      return r ^ xorOut;
   endfunction

   // Single comparison point: counts and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one beat on each instance and wait (bounded) for it to be taken;
   // waitCycles reports how many cycles s_ready was low before acceptance.
   task automatic applyBeatA(input logic [31:0] d, input bit last, output int waitCycles);
      aIf.s_valid = 1'b1; aIf.s_data = d; aIf.s_last = last;
      waitCycles = 0;
      @(negedge clk);
      while (!aIf.s_ready && waitCycles < 50) begin @(negedge clk); waitCycles++; end
      if (!aIf.s_ready) checkOutput("A_acceptTimeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      aIf.s_valid = 1'b0;
   endtask

   task automatic applyBeatB(input logic [7:0] d, input bit last, output int waitCycles);
      bIf.s_valid = 1'b1; bIf.s_data = d; bIf.s_last = last;
      waitCycles = 0;
      @(negedge clk);
      while (!bIf.s_ready && waitCycles < 50) begin @(negedge clk); waitCycles++; end
      if (!bIf.s_ready) checkOutput("B_acceptTimeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bIf.s_valid = 1'b0;
   endtask

   task automatic applyBeatC(input logic [7:0] d, input bit last, input int gap);
      int waitCycles;
      repeat (gap) begin @(posedge clk); #1; end
      cIf.s_valid = 1'b1; cIf.s_data = d; cIf.s_last = last;
      waitCycles = 0;
      @(negedge clk);
      while (!cIf.s_ready && waitCycles < 50) begin @(negedge clk); waitCycles++; end
      if (!cIf.s_ready) checkOutput("C_acceptTimeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      cIf.s_valid = 1'b0;
   endtask

   task automatic applyBeatD(input logic [7:0] d, input bit last);
      int waitCycles;
      dIf.s_valid = 1'b1; dIf.s_data = d; dIf.s_last = last;
      waitCycles = 0;
      @(negedge clk);
      while (!dIf.s_ready && waitCycles < 50) begin @(negedge clk); waitCycles++; end
      if (!dIf.s_ready) checkOutput("D_acceptTimeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      dIf.s_valid = 1'b0;
   endtask

   // Sends "123456789" on the CCITT instance after queuing its known answer.
   task automatic applyStimulusDigitsB();
      int n;
      bExpCrc.push_back(64'h29B1);
      bExpBeats.push_back(64'd9);
      for (int i = 0; i < 9; i++) applyBeatB(digits[i], (i == 8), n);
   endtask

   // Result monitors: pop the scoreboard whenever a result is handed over.
   always @(negedge clk) begin
      if (rst_n && aIf.m_valid && aIf.m_ready) begin
         if (aExpCrc.size() == 0) checkOutput("A_unexpected", 64'd1, 64'd0);
         else begin
            checkOutput("A_crc", 64'(aIf.m_crc), aExpCrc.pop_front());
            checkOutput("A_beats", 64'(aIf.m_beats), aExpBeats.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bIf.m_valid && bIf.m_ready) begin
         if (bExpCrc.size() == 0) checkOutput("B_unexpected", 64'd1, 64'd0);
         else begin
            checkOutput("B_crc", 64'(bIf.m_crc), bExpCrc.pop_front());
            checkOutput("B_beats", 64'(bIf.m_beats), bExpBeats.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cIf.m_valid && cIf.m_ready) begin
         if (cExpCrc.size() == 0) checkOutput("C_unexpected", 64'd1, 64'd0);
         else begin
            checkOutput("C_crc", 64'(cIf.m_crc), cExpCrc.pop_front());
            checkOutput("C_beats", 64'(cIf.m_beats), cExpBeats.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && dIf.m_valid && dIf.m_ready) begin
         if (dExpCrc.size() == 0) checkOutput("D_unexpected", 64'd1, 64'd0);
         else begin
            checkOutput("D_crc", 64'(dIf.m_crc), dExpCrc.pop_front());
            checkOutput("D_beats", 64'(dIf.m_beats), dExpBeats.pop_front());
         end
      end
   end

   // Main test sequence.
   initial begin
      int          n;
      int          gap;
      logic [63:0] crc;
      logic [7:0]  byteVal;
      logic [7:0]  frame2 [3];

      for (int i = 0; i < 9; i++) digits[i] = 8'h31 + 8'(i);
      rst_n = 1'b0;
      aIf.s_valid = 0; aIf.s_data = '0; aIf.s_last = 0; aIf.clear = 0; aIf.m_ready = 1;
      bIf.s_valid = 0; bIf.s_data = '0; bIf.s_last = 0; bIf.clear = 0; bIf.m_ready = 1;
      cIf.s_valid = 0; cIf.s_data = '0; cIf.s_last = 0; cIf.clear = 0; cIf.m_ready = 0;
      dIf.s_valid = 0; dIf.s_data = '0; dIf.s_last = 0; dIf.clear = 0; dIf.m_ready = 1;

      repeat (2) @(negedge clk);
      checkOutput("rst_A_mValid", 64'(aIf.m_valid), 64'd0);
      checkOutput("rst_A_sReady", 64'(aIf.s_ready), 64'd1);
      checkOutput("rst_B_mCrc", 64'(bIf.m_crc), 64'd0);
      checkOutput("rst_B_mBeats", 64'(bIf.m_beats), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Default instance: single zero beat, with one-cycle result latency.
      aExpCrc.push_back(64'h000); aExpBeats.push_back(64'd1);
      applyBeatA(32'h0, 1'b1, n);
      checkOutput("A_latency", 64'(aIf.m_valid), 64'd1);
      @(posedge clk); #1;
      crc = refFinal(refStep(64'h0, 128'h1, 10, 32, 64'h233, 1'b0), 10, 1'b0, 64'h0);
      aExpCrc.push_back(crc); aExpBeats.push_back(64'd1);
      applyBeatA(32'h1, 1'b1, n);
      repeat (3) @(posedge clk); #1;

      // CCITT known answer.
      applyStimulusDigitsB();
      repeat (3) @(posedge clk); #1;

      // CRC-32 with random input gaps and a 5-cycle result stall.
      cExpCrc.push_back(64'hCBF43926); cExpBeats.push_back(64'd9);
      for (int i = 0; i < 9; i++) begin
         gap = $urandom_range(0, 2);
         applyBeatC(digits[i], (i == 8), gap);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("C_stallValid", 64'(cIf.m_valid), 64'd1);
         checkOutput("C_stallReady", 64'(cIf.s_ready), 64'd0);
         checkOutput("C_stallCrc", 64'(cIf.m_crc), 64'hCBF43926);
         checkOutput("C_stallBeats", 64'(cIf.m_beats), 64'd9);
      end
      @(posedge clk); #1;
      cIf.m_ready = 1'b1;
      repeat (3) @(posedge clk); #1;

      // clear after 3 beats (with a beat offered in the same cycle), then a full frame.
      for (int i = 0; i < 3; i++) applyBeatB(8'hA0 + 8'(i), 1'b0, n);
      bIf.clear = 1'b1; bIf.s_valid = 1'b1; bIf.s_data = 8'h55; bIf.s_last = 1'b1;
      @(posedge clk); #1;
      bIf.clear = 1'b0; bIf.s_valid = 1'b0; bIf.s_last = 1'b0;
      checkOutput("B_clearNoResult", 64'(bIf.m_valid), 64'd0);
      applyStimulusDigitsB();
      repeat (3) @(posedge clk); #1;

      // clear in DONE must not drop the pending result.
      bIf.m_ready = 1'b0;
      applyStimulusDigitsB();
      bIf.clear = 1'b1;
      @(posedge clk); #1;
      bIf.clear = 1'b0;
      checkOutput("B_clearDoneHold", 64'(bIf.m_valid), 64'd1);
      bIf.m_ready = 1'b1;
      repeat (3) @(posedge clk); #1;

      // Back-to-back random frames with m_ready high: one dead cycle, full throughput.
      crc = 64'hFFFF;
      for (int i = 0; i < 4; i++) begin
         byteVal = 8'($urandom);
         crc = refStep(crc, 128'(byteVal), 16, 8, 64'h1021, 1'b0);
         if (i == 0) begin
            bExpCrc.push_back(64'h0); bExpBeats.push_back(64'd4);
         end
         applyBeatB(byteVal, (i == 3), n);
      end
      bExpCrc[bExpCrc.size()-1] = refFinal(crc, 16, 1'b0, 64'h0);
      crc = 64'hFFFF;
      for (int i = 0; i < 3; i++) begin
         frame2[i] = 8'($urandom);
         crc = refStep(crc, 128'(frame2[i]), 16, 8, 64'h1021, 1'b0);
      end
      bExpCrc.push_back(refFinal(crc, 16, 1'b0, 64'h0)); bExpBeats.push_back(64'd3);
      for (int i = 0; i < 3; i++) begin
         applyBeatB(frame2[i], (i == 2), n);
         if (i == 0) checkOutput("B_deadCycles", 64'(n), 64'd1);
         if (i == 1) checkOutput("B_throughput", 64'(n), 64'd0);
      end
      repeat (3) @(posedge clk); #1;

      // Saturating 2-bit counter over a 6-beat frame.
      crc = 64'hFFFF;
      for (int i = 0; i < 6; i++) begin
         byteVal = 8'($urandom);
         crc = refStep(crc, 128'(byteVal), 16, 8, 64'h1021, 1'b0);
         if (i == 5) begin
            dExpCrc.push_back(refFinal(crc, 16, 1'b0, 64'h0));
            dExpBeats.push_back(64'd3);
         end
         applyBeatD(byteVal, (i == 5));
      end
      repeat (3) @(posedge clk); #1;

      // Asynchronous reset mid-frame, then a clean frame.
      for (int i = 0; i < 3; i++) applyBeatB(8'h10 + 8'(i), 1'b0, n);
      rst_n = 1'b0;
      #1;
      checkOutput("rstMid_mValid", 64'(bIf.m_valid), 64'd0);
      checkOutput("rstMid_sReady", 64'(bIf.s_ready), 64'd1);
      checkOutput("rstMid_mCrc", 64'(bIf.m_crc), 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulusDigitsB();

      // Drain all scoreboards (bounded).
      n = 0;
      while ((aExpCrc.size() + bExpCrc.size() + cExpCrc.size() + dExpCrc.size()) != 0 && n < 100) begin
         @(posedge clk); n++;
      end
      checkOutput("drainPending",
                  64'(aExpCrc.size() + bExpCrc.size() + cExpCrc.size() + dExpCrc.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised streaming CRC engine, successor to the fixed CRC-10 block. It accepts a frame of DATA_W-bit beats over a valid/ready handshake and folds all DATA_W bits of every beat in a single cycle. CRC width, polynomial, initial value, bit order, output reflection and final XOR are set per instance. It returns the finished CRC and the frame beat count over a second valid/ready handshake. It sits between packet framers and link-layer checkers.

## Interface
- CRC_W, 10, CRC width in bits (1..64)
- POLY, 10'h233, generator polynomial without the x^CRC_W term (default x^10+x^9+x^5+x^4+x+1)
- DATA_W, 32, data bits per beat (1..128)
- INIT, 0, CRC register value at frame start
- XOR_OUT, 0, value XORed into the final CRC
- LSB_FIRST, 0, 1 = s_data[0] is folded first, 0 = s_data[DATA_W-1] is folded first
- REFLECT_OUT, 0, 1 = bit-reverse the CRC before XOR_OUT
- CNT_W, 16, width of the beat counter
- clk  in  1  clock, all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  engine can accept a beat
- s_data  in  DATA_W  input beat
- s_last  in  1  final beat of the frame
- clear  in  1  synchronous abort; discards the frame in progress
- m_valid  out  1  result valid
- m_ready  in  1  result consumed
- m_crc  out  CRC_W  final CRC
- m_beats  out  CNT_W  beats in the frame, saturating at all-ones

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: crc_reg=INIT, cnt=0, m_valid=0, m_crc=0, m_beats=0. s_ready=1 after reset (IDLE).
- s_ready=1 in IDLE and RUN; s_ready=0 in DONE.
- Accept condition: s_valid && s_ready.
- Per-bit step, non-augmented Galois form: fb = crc[CRC_W-1] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0).
- A beat applies DATA_W such steps in the order set by LSB_FIRST, in one combinational unroll.
- Step base: INIT for an accepted beat in IDLE; crc_reg for an accepted beat in RUN.
- IDLE, accept with s_last=0: crc_reg = step(INIT, data), cnt=1, go to RUN.
- RUN, accept with s_last=0: crc_reg = step(crc_reg, data), cnt=cnt+1 (saturating), stay in RUN.
- IDLE or RUN, accept with s_last=1:
  - m_crc = (REFLECT_OUT ? reverse(next) : next) ^ XOR_OUT, where next is the stepped value.
  - m_beats = the incremented count.
  - m_valid=1, go to DONE.
- DONE: m_crc and m_beats are held stable. When m_valid && m_ready, m_valid=0, crc_reg=INIT, cnt=0, go to IDLE.
- clear=1 in IDLE or RUN: crc_reg=INIT, cnt=0, go to IDLE. Any beat accepted in that cycle is dropped. clear has priority over accept.
- clear=1 in DONE: ignored. A result, once produced, is always delivered.
- s_valid=0 in RUN holds all state indefinitely (bubbles allowed).
- A single-beat frame (s_last=1 in IDLE) is legal.

## Timing
- Result latency: m_valid rises on the edge that accepts the s_last beat (registered, one cycle after the beat was presented).
- Throughput: one beat per cycle while in RUN.
- Frame turnaround: at least 1 dead cycle. DONE is held at least one cycle; s_ready returns the cycle after the m_ready handshake.
- s_ready is a function of state only; it has no combinational path from m_ready.
- Asynchronous reset mid-frame: the partial CRC is lost and outputs return to their reset values immediately.
- m_crc and m_beats change only on entry to DONE.

## Test plan
- CRC-16/CCITT-FALSE (CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, DATA_W=8, LSB_FIRST=0, REFLECT_OUT=0, XOR_OUT=0); ASCII "123456789" as 9 beats -> m_crc=16'h29B1, m_beats=9.
- CRC-32 (POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF, LSB_FIRST=1, REFLECT_OUT=1, DATA_W=8); "123456789" with random s_valid gaps and m_ready held low for 5 cycles -> m_crc=32'hCBF43926, m_beats=9; s_ready=0 throughout the stall, result held stable.
- Default instance:
  - Single beat 32'h0, s_last=1 -> m_crc=10'h000, m_beats=1, m_valid 1 cycle after accept.
  - Single beat 32'h1 -> m_crc matches the bench's bit-serial reference model.
- clear asserted mid-frame after 3 beats, then "123456789" sent (CCITT config) -> 16'h29B1, m_beats=9. clear asserted in DONE -> result still delivered.
- Back-to-back frames with m_ready tied high -> exactly 1 dead cycle between frames; each CRC is independent. CNT_W=2 with 6 beats -> m_beats=2'b11.
- rst_n pulsed low mid-frame -> m_valid=0, s_ready=1, m_crc=0. The next frame computes correctly.
